scanline_filler: RTL and testbench



---
 rtl/scanline_filler.sv | 185 ++++++++++++++++++
 tb/tb_scanline_filler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/scanline_filler.sv
// scanline_filler: delays the Gigatron OUT stream by one line and fills blank scanlines
// with the RGB of the last content line. Define SCANLINE_FILLER_DIM_EN to halve filled RGB.
module scanline_filler #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned MAX_FILL = 3
) (
    input  logic       hdmi_pixel_clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic [7:0] in_out,
    input  logic       fill_en,
    output logic [7:0] out_out,
    output logic       fill_active
);
    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_MAX  = '1;
    localparam logic [1:0]        FILL_MAX = 2'(MAX_FILL);

    logic [1:0]        r_wsel, r_dsel, r_hsel;
    logic [1:0]        w_wsel_n, w_dsel_n, w_hsel_n;
    logic              r_hold_valid, w_hold_valid_n;
    logic              r_d_valid, w_d_valid_n;
    logic              r_d_fillable, w_d_fillable_n;
    logic [1:0]        r_fill_cnt, w_fill_cnt_n;
    logic [ADDR_W-1:0] r_idx, w_idx_cur;
    logic              r_prev_hs, r_content, r_vsync;
    logic              w_samp, w_line_start, w_samp_content, w_samp_vsync;

    assign w_samp         = pix_en & ~rst;
    assign w_line_start   = pix_en & r_prev_hs & ~in_out[6];
    assign w_idx_cur      = w_line_start ? '0 : r_idx;
    assign w_samp_content = (&in_out[7:6]) & (|in_out[5:0]);
    assign w_samp_vsync   = ~in_out[7];

    // Bank role rotation and fill bookkeeping at each line start.
    always_comb begin
        w_wsel_n       = r_wsel;
        w_dsel_n       = r_dsel;
        w_hsel_n       = r_hsel;
        w_hold_valid_n = r_hold_valid;
        w_d_valid_n    = r_d_valid;
        w_d_fillable_n = r_d_fillable;
        w_fill_cnt_n   = r_fill_cnt;
        if (w_line_start) begin
            w_d_valid_n    = 1'b1;
            w_dsel_n       = r_wsel;
            // Decided on the count before this line's increment; vsync lines never fill.
            w_d_fillable_n = ~r_content & ~r_vsync & r_hold_valid & (r_fill_cnt < FILL_MAX);
            if (r_vsync) begin
                w_fill_cnt_n = FILL_MAX;
            end else if (r_content) begin
                w_hsel_n       = r_wsel;
                w_hold_valid_n = 1'b1;
                w_fill_cnt_n   = 2'd0;
            end else if (r_fill_cnt < FILL_MAX) begin
                w_fill_cnt_n = r_fill_cnt + 2'd1;
            end
            // New W is whichever bank is neither the new D nor the H bank.
            if (r_content && !r_vsync) begin
                w_wsel_n = r_dsel;
            end else begin
                w_wsel_n = 2'd3 - r_wsel - r_hsel;
            end
        end
    end

    always_ff @(posedge hdmi_pixel_clk) begin
        if (rst) begin
            r_wsel       <= 2'd0;
            r_dsel       <= 2'd1;
            r_hsel       <= 2'd2;
            r_hold_valid <= 1'b0;
            r_d_valid    <= 1'b0;
            r_d_fillable <= 1'b0;
            r_fill_cnt   <= FILL_MAX;
            r_idx        <= '0;
            r_prev_hs    <= 1'b1;
            r_content    <= 1'b0;
            r_vsync      <= 1'b0;
        end else if (pix_en) begin
            r_wsel       <= w_wsel_n;
            r_dsel       <= w_dsel_n;
            r_hsel       <= w_hsel_n;
            r_hold_valid <= w_hold_valid_n;
            r_d_valid    <= w_d_valid_n;
            r_d_fillable <= w_d_fillable_n;
            r_fill_cnt   <= w_fill_cnt_n;
            r_idx        <= (w_idx_cur == IDX_MAX) ? IDX_MAX : w_idx_cur + 1'b1;
            r_prev_hs    <= in_out[6];
            r_content    <= w_samp_content | (r_content & ~w_line_start);
            r_vsync      <= w_samp_vsync | (r_vsync & ~w_line_start);
        end
    end

    // Each bank is either written (role W) or read in a given sample slot.
    logic [7:0] w_rd [3];
    for (genvar g = 0; g < 3; g++) begin : g_bank
        logic [7:0] r_mem [DEPTH];
        logic [7:0] r_rd;
        always_ff @(posedge hdmi_pixel_clk) begin
            if (w_samp) begin
                if (w_wsel_n == 2'(g)) begin
                    r_mem[w_idx_cur] <= in_out;
                end
                r_rd <= r_mem[w_idx_cur];
            end
        end
        assign w_rd[g] = r_rd;
    end

    logic       r_s1_en, r_s1_valid, r_s1_fill;
    logic [1:0] r_s1_dsel, r_s1_hsel;
    logic       r_s2_en, r_s2_fill;
    logic [7:0] r_s2_byte;
    logic [7:0] w_d_byte, w_h_byte, w_s2_byte;
    logic [5:0] w_fill_rgb;
    logic       w_s2_fill;

    always_comb begin
        w_d_byte = w_rd[0];
        w_h_byte = w_rd[0];
        case (r_s1_dsel)
            2'd1:    w_d_byte = w_rd[1];
            2'd2:    w_d_byte = w_rd[2];
            default: w_d_byte = w_rd[0];
        endcase
        case (r_s1_hsel)
            2'd1:    w_h_byte = w_rd[1];
            2'd2:    w_h_byte = w_rd[2];
            default: w_h_byte = w_rd[0];
        endcase
    end

`ifdef SCANLINE_FILLER_DIM_EN
    assign w_fill_rgb = {1'b0, w_h_byte[5], 1'b0, w_h_byte[3], 1'b0, w_h_byte[1]};
`else
    assign w_fill_rgb = w_h_byte[5:0];
`endif

    always_comb begin
        w_s2_byte = 8'hC0;
        w_s2_fill = 1'b0;
        if (r_s1_valid) begin
            if (r_s1_fill) begin
                w_s2_byte = {w_d_byte[7:6], w_fill_rgb};
                w_s2_fill = 1'b1;
            end else begin
                w_s2_byte = w_d_byte;
            end
        end
    end

    always_ff @(posedge hdmi_pixel_clk) begin
        if (rst) begin
            r_s1_en     <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_fill   <= 1'b0;
            r_s1_dsel   <= 2'd1;
            r_s1_hsel   <= 2'd2;
            r_s2_en     <= 1'b0;
            r_s2_byte   <= 8'hC0;
            r_s2_fill   <= 1'b0;
            out_out     <= 8'hC0;
            fill_active <= 1'b0;
        end else begin
            r_s1_en <= pix_en;
            if (pix_en) begin
                r_s1_valid <= w_d_valid_n;
                r_s1_fill  <= fill_en & w_d_fillable_n;
                r_s1_dsel  <= w_dsel_n;
                r_s1_hsel  <= w_hsel_n;
            end
            r_s2_en <= r_s1_en;
            if (r_s1_en) begin
                r_s2_byte <= w_s2_byte;
                r_s2_fill <= w_s2_fill;
            end
            if (r_s2_en) begin
                out_out     <= r_s2_byte;
                fill_active <= r_s2_fill;
            end
        end
    end

endmodule

// File: tb/tb_scanline_filler.sv
// Directed bench for scanline_filler: table of lines with hand-computed pixel-10 outputs,
// plus reset, overflow/latency and mid-line reset sequences.
module tb_scanline_filler;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned MAX_FILL = 3;
    localparam int          LEN      = 40;
`ifdef SCANLINE_FILLER_DIM_EN
    localparam logic [7:0] FILLED = 8'hD5;
`else
    localparam logic [7:0] FILLED = 8'hFF;
`endif

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       pix_en  = 1'b0;
    logic [7:0] in_out  = 8'hC0;
    logic       fill_en = 1'b1;
    logic [7:0] out_out;
    logic       fill_active;

    always #5 clk = ~clk;

    scanline_filler #(.ADDR_W(ADDR_W), .MAX_FILL(MAX_FILL)) dut (
        .hdmi_pixel_clk(clk),
        .rst           (rst),
        .pix_en        (pix_en),
        .in_out        (in_out),
        .fill_en       (fill_en),
        .out_out       (out_out),
        .fill_active   (fill_active)
    );

    typedef enum int {KBlank, KContent, KVsync} kind_e;
    typedef struct {
        kind_e      kind;
        logic [5:0] rgb10;
        logic       fen;
        logic       chk;
        logic       full;
        logic [7:0] exp10;
        logic       exp_fa;
    } vec_t;

    int         checks = 0;
    int         passes = 0;
    logic [7:0] line_buf  [300];
    logic [7:0] prev_buf  [300];
    logic [7:0] out_cap   [300];
    logic [7:0] early_cap [300];
    logic       fa_cap    [300];
    vec_t       vecs      [21];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic make_line(input kind_e kind, input logic [5:0] rgb10, input int len);
        for (int i = 0; i < len; i++) begin
            case (kind)
                KVsync:   line_buf[i] = (i < 4) ? 8'h00 : 8'h40;
                KContent: line_buf[i] = (i < 4) ? 8'h80 : {2'b11, 6'(i * 5)};
                default:  line_buf[i] = (i < 4) ? 8'h80 : 8'hC0;
            endcase
        end
        if (kind == KContent) line_buf[10] = {2'b11, rgb10};
    endtask

    // One sample every 4 clocks; output read 2.5 clocks after the sampling edge.
    task automatic send_sample(input logic [7:0] b, input logic fen, output logic [7:0] o,
                               output logic f, output logic [7:0] early);
        @(negedge clk);
        pix_en  = 1'b1;
        in_out  = b;
        fill_en = fen;
        @(negedge clk);
        pix_en = 1'b0;
        @(negedge clk);
        early = out_out;
        @(negedge clk);
        o = out_out;
        f = fill_active;
    endtask

    task automatic send_line(input int len, input logic fen);
        for (int i = 0; i < len; i++) begin
            send_sample(line_buf[i], fen, out_cap[i], fa_cap[i], early_cap[i]);
        end
    endtask

    initial begin
        int errs;
        vecs[0]  = '{KContent, 6'h3F, 1'b1, 1'b0, 1'b0, 8'h00,  1'b0};
        vecs[1]  = '{KBlank,   6'h00, 1'b1, 1'b1, 1'b1, 8'hFF,  1'b0};
        vecs[2]  = '{KBlank,   6'h00, 1'b1, 1'b1, 1'b0, FILLED, 1'b1};
        vecs[3]  = '{KBlank,   6'h00, 1'b1, 1'b1, 1'b0, FILLED, 1'b1};
        vecs[4]  = '{KContent, 6'h2A, 1'b1, 1'b1, 1'b0, FILLED, 1'b1};
        vecs[5]  = '{KContent, 6'h00, 1'b1, 1'b1, 1'b1, 8'hEA,  1'b0};
        vecs[6]  = '{KContent, 6'h3F, 1'b1, 1'b1, 1'b1, 8'hC0,  1'b0};
        vecs[7]  = '{KBlank,   6'h00, 1'b1, 1'b1, 1'b1, 8'hFF,  1'b0};
        vecs[8]  = '{KBlank,   6'h00, 1'b1, 1'b1, 1'b0, FILLED, 1'b1};
        vecs[9]  = '{KBlank,   6'h00, 1'b1, 1'b1, 1'b0, FILLED, 1'b1};
        vecs[10] = '{KBlank,   6'h00, 1'b1, 1'b1, 1'b0, FILLED, 1'b1};
        vecs[11] = '{KBlank,   6'h00, 1'b1, 1'b1, 1'b1, 8'hC0,  1'b0};
        vecs[12] = '{KContent, 6'h3F, 1'b1, 1'b1, 1'b1, 8'hC0,  1'b0};
        vecs[13] = '{KVsync,   6'h00, 1'b1, 1'b1, 1'b1, 8'hFF,  1'b0};
        vecs[14] = '{KBlank,   6'h00, 1'b1, 1'b1, 1'b1, 8'h40,  1'b0};
        vecs[15] = '{KBlank,   6'h00, 1'b1, 1'b1, 1'b1, 8'hC0,  1'b0};
        vecs[16] = '{KBlank,   6'h00, 1'b1, 1'b1, 1'b1, 8'hC0,  1'b0};
        vecs[17] = '{KContent, 6'h3F, 1'b1, 1'b1, 1'b1, 8'hC0,  1'b0};
        vecs[18] = '{KBlank,   6'h00, 1'b0, 1'b1, 1'b1, 8'hFF,  1'b0};
        vecs[19] = '{KBlank,   6'h00, 1'b0, 1'b1, 1'b1, 8'hC0,  1'b0};
        vecs[20] = '{KBlank,   6'h00, 1'b1, 1'b1, 1'b0, FILLED, 1'b1};

        // Reset held 5 clocks with random input traffic.
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pix_en = i[0];
            in_out = 8'($urandom);
            @(posedge clk);
            #1;
            if (out_out !== 8'hC0 || fill_active !== 1'b0) errs++;
        end
        @(negedge clk);
        rst    = 1'b0;
        pix_en = 1'b0;
        check_int("reset_hold", errs, 0);

        // 200 visible samples with no line start: output stays idle.
        errs = 0;
        for (int i = 0; i < 200; i++) begin
            line_buf[i] = {2'b11, 6'($urandom)};
        end
        send_line(200, 1'b1);
        for (int i = 0; i < 200; i++) begin
            if (out_cap[i] !== 8'hC0 || fa_cap[i] !== 1'b0) errs++;
        end
        check_int("first_line_idle", errs, 0);

        for (int k = 0; k < 21; k++) begin
            prev_buf = line_buf;
            make_line(vecs[k].kind, vecs[k].rgb10, LEN);
            send_line(LEN, vecs[k].fen);
            if (vecs[k].chk) begin
                check8($sformatf("line%0d_px10", k), out_cap[10], vecs[k].exp10);
                check8($sformatf("line%0d_fill_active", k), 8'(fa_cap[10]),
                       8'(vecs[k].exp_fa));
            end
            if (vecs[k].full) begin
                errs = 0;
                for (int i = 0; i < LEN; i++) begin
                    if (out_cap[i] !== prev_buf[i] || fa_cap[i] !== 1'b0) errs++;
                end
                check_int($sformatf("line%0d_passthrough", k), errs, 0);
            end
        end

        // 300-sample line: entries past 255 collapse onto the last slot.
        for (int i = 0; i < 300; i++) begin
            if (i < 4)         line_buf[i] = 8'h80;
            else if (i == 299) line_buf[i] = 8'hED;
            else if (i > 255)  line_buf[i] = 8'hD1;
            else               line_buf[i] = {2'b11, 6'(i)};
        end
        send_line(300, 1'b1);
        prev_buf = line_buf;
        for (int i = 0; i < 256; i++) begin
            line_buf[i] = (i < 4) ? 8'h80 : 8'hC0;
        end
        send_line(256, 1'b0);
        check8("overflow_last_entry", out_cap[255], 8'hED);
        errs = 0;
        for (int i = 0; i < 255; i++) begin
            if (out_cap[i] !== prev_buf[i]) errs++;
        end
        check_int("overflow_restart_idx0", errs, 0);
        check8("latency_not_early", early_cap[5], prev_buf[4]);
        check8("latency_on_time", out_cap[5], prev_buf[5]);

        // Reset in the middle of a line.
        make_line(KContent, 6'h3F, LEN);
        for (int i = 0; i < 20; i++) begin
            send_sample(line_buf[i], 1'b1, out_cap[i], fa_cap[i], early_cap[i]);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check8("midline_reset_out", out_out, 8'hC0);
        check8("midline_reset_fill", 8'(fill_active), 8'h00);
        rst = 1'b0;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            line_buf[i] = 8'hD5;
        end
        send_line(10, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (out_cap[i] !== 8'hC0 || fa_cap[i] !== 1'b0) errs++;
        end
        check_int("after_reset_idle", errs, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
